// File: rtl/lvda_pio_pkg.sv
// Shared definitions for the LVDA discrete-latch PIO/DCS scheduler.
package lvda_pio_pkg;

    localparam int unsigned ADDR_W_DEF  = 5;
    localparam int unsigned PULSE_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } pio_state_e;

    // Latch addresses, bit0 = A3 ... bit4 = A7
    localparam logic [4:0] LATCH_EMA  = 5'b00100;
    localparam logic [4:0] LATCH_SSDO = 5'b01010;
    localparam logic [4:0] LATCH_CODE = 5'b01101;
    localparam logic [4:0] LATCH_MODA = 5'b00001;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arbiter2 (
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       LAST_GNT,
    input  logic       ENABLE,
    output logic [1:0] GNT
);

    always_comb begin
        GNT = '0;
        if (ENABLE) begin
            if (REQ0 && REQ1) begin
                GNT = LAST_GNT ? 2'b01 : 2'b10;
            end else if (REQ0) begin
                GNT = 2'b01;
            end else if (REQ1) begin
                GNT = 2'b10;
            end
        end
    end

endmodule

// File: rtl/pio_latch_scheduler.sv
// Shares the LVDA latch address decode between the PIO (req0) and DCS (req1) paths:
// set strobe in W8, optional auto-clear strobe in a later Y8 after DUR W8 phases.
module pio_latch_scheduler
    import lvda_pio_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned PULSE_W = PULSE_W_DEF
) (
    input  logic               SIM_CLK,
    input  logic               SIM_RST,
    input  logic               W8,
    input  logic               Y8,
    input  logic               REQ0,
    input  logic [ADDR_W-1:0]  ADDR0,
    input  logic               PULSE0,
    input  logic [PULSE_W-1:0] DUR0,
    input  logic               REQ1,
    input  logic [ADDR_W-1:0]  ADDR1,
    input  logic               PULSE1,
    input  logic [PULSE_W-1:0] DUR1,
    output logic               ACK0,
    output logic               ACK1,
    output logic               ADV,
    output logic [ADDR_W-1:0]  A_DV,
    output logic               SET_STB,
    output logic               CLR_STB,
    output logic               BUSY,
    output logic               LAST_GNT
);

    pio_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               pulse_q, pulse_d;
    logic [PULSE_W-1:0] dur_q, dur_d;
    logic [PULSE_W-1:0] cnt_q, cnt_d;
    logic               gid_q, gid_d;
    logic               rr_last_q, rr_last_d;
    logic               last_gnt_q, last_gnt_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic [1:0]         gnt;

    // rr_last_q resets to 1 so the first tie goes to req0, while the visible
    // LAST_GNT output still reads 0 until a grant happens.
    rr_arbiter2 u_arb (
        .REQ0     (REQ0),
        .REQ1     (REQ1),
        .LAST_GNT (rr_last_q),
        .ENABLE   (state_q == ST_IDLE),
        .GNT      (gnt)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pulse_d    = pulse_q;
        dur_d      = dur_q;
        cnt_d      = cnt_q;
        gid_d      = gid_q;
        rr_last_d  = rr_last_q;
        last_gnt_d = last_gnt_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt[0] || gnt[1]) begin
                    gid_d      = gnt[1];
                    addr_d     = gnt[1] ? ADDR1 : ADDR0;
                    pulse_d    = gnt[1] ? PULSE1 : PULSE0;
                    dur_d      = gnt[1] ? DUR1 : DUR0;
                    rr_last_d  = gnt[1];
                    last_gnt_d = gnt[1];
                    state_d    = ST_ARM;
                end
            end
            ST_ARM: begin
                if (W8) begin
                    if (pulse_q) begin
                        state_d = ST_HOLD;
                        cnt_d   = dur_q;
                    end else begin
                        state_d = ST_DONE;
                        ack0_d  = ~gid_q;
                        ack1_d  = gid_q;
                    end
                end
            end
            ST_HOLD: begin
                // The clear has priority over a coincident W8; cnt never wraps.
                if (cnt_q == '0) begin
                    if (Y8) begin
                        state_d = ST_DONE;
                        ack0_d  = ~gid_q;
                        ack1_d  = gid_q;
                    end
                end else if (W8) begin
                    cnt_d = cnt_q - PULSE_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            pulse_q    <= 1'b0;
            dur_q      <= '0;
            cnt_q      <= '0;
            gid_q      <= 1'b0;
            rr_last_q  <= 1'b1;
            last_gnt_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pulse_q    <= pulse_d;
            dur_q      <= dur_d;
            cnt_q      <= cnt_d;
            gid_q      <= gid_d;
            rr_last_q  <= rr_last_d;
            last_gnt_q <= last_gnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
        end
    end

    assign ADV      = (state_q != ST_IDLE);
    assign BUSY     = (state_q != ST_IDLE);
    assign A_DV     = ADV ? addr_q : '0;
    assign SET_STB  = (state_q == ST_ARM) && W8;
    assign CLR_STB  = (state_q == ST_HOLD) && (cnt_q == '0) && Y8;
    assign ACK0     = ack0_q;
    assign ACK1     = ack1_q;
    assign LAST_GNT = last_gnt_q;

endmodule

// File: tb/tb_pio_latch_scheduler.sv
// Bench for pio_latch_scheduler: per-scenario transaction model predicts every
// output cycle by cycle from the request list and the W8/Y8 phase pattern.
module tb_pio_latch_scheduler;
    import lvda_pio_pkg::*;

    localparam int MAXC = 1600;
    localparam int INF  = 1 << 30;

    typedef struct {
        int         earliest;
        int         gap;
        logic [4:0] addr;
        logic       pulse;
        logic [3:0] dur;
    } req_t;

    logic       SIM_CLK = 1'b0;
    logic       SIM_RST;
    logic       W8, Y8, REQ0, REQ1, PULSE0, PULSE1;
    logic [4:0] ADDR0, ADDR1, A_DV;
    logic [3:0] DUR0, DUR1;
    logic       ACK0, ACK1, ADV, SET_STB, CLR_STB, BUSY, LAST_GNT;

    int errors = 0;
    int checks = 0;

    req_t q0[$];
    req_t q1[$];
    bit         w8_s    [MAXC];
    bit         y8_s    [MAXC];
    logic       req_s   [2][MAXC];
    logic [4:0] addr_s  [2][MAXC];
    logic       pulse_s [2][MAXC];
    logic [3:0] dur_s   [2][MAXC];
    bit         e_adv   [MAXC];
    bit         e_set   [MAXC];
    bit         e_clr   [MAXC];
    bit         e_last  [MAXC];
    bit         e_ack   [2][MAXC];
    logic [4:0] e_addr  [MAXC];

    always #5 SIM_CLK = ~SIM_CLK;

    pio_latch_scheduler #(.ADDR_W(5), .PULSE_W(4)) dut (
        .SIM_CLK  (SIM_CLK),
        .SIM_RST  (SIM_RST),
        .W8       (W8),
        .Y8       (Y8),
        .REQ0     (REQ0),
        .ADDR0    (ADDR0),
        .PULSE0   (PULSE0),
        .DUR0     (DUR0),
        .REQ1     (REQ1),
        .ADDR1    (ADDR1),
        .PULSE1   (PULSE1),
        .DUR1     (DUR1),
        .ACK0     (ACK0),
        .ACK1     (ACK1),
        .ADV      (ADV),
        .A_DV     (A_DV),
        .SET_STB  (SET_STB),
        .CLR_STB  (CLR_STB),
        .BUSY     (BUSY),
        .LAST_GNT (LAST_GNT)
    );

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_scenario();
        q0.delete();
        q1.delete();
        for (int c = 0; c < MAXC; c++) begin
            w8_s[c] = 1'b0;
            y8_s[c] = 1'b0;
            for (int r = 0; r < 2; r++) begin
                addr_s[r][c]  = 5'($urandom);
                pulse_s[r][c] = 1'($urandom);
                dur_s[r][c]   = 4'($urandom);
            end
        end
    endtask

    // Grant order, set/clear/ACK cycles derived from the phase pattern by counting.
    task automatic build_model(input int len);
        int   idle_from, last, g, s, k, a, cntw, win;
        int   ready [2];
        int   r [2];
        req_t op;
        for (int c = 0; c < MAXC; c++) begin
            req_s[0][c] = 1'b0; req_s[1][c] = 1'b0;
            e_adv[c] = 1'b0; e_set[c] = 1'b0; e_clr[c] = 1'b0; e_last[c] = 1'b0;
            e_ack[0][c] = 1'b0; e_ack[1][c] = 1'b0; e_addr[c] = '0;
        end
        idle_from = 0; last = 1; ready[0] = 0; ready[1] = 0;
        while (q0.size() != 0 || q1.size() != 0) begin
            r[0] = (q0.size() != 0) ? imax(q0[0].earliest, ready[0] + q0[0].gap) : INF;
            r[1] = (q1.size() != 0) ? imax(q1[0].earliest, ready[1] + q1[0].gap) : INF;
            g = imax(idle_from, imin(r[0], r[1]));
            if (r[0] <= g && r[1] <= g) win = (last == 0) ? 1 : 0;
            else                        win = (r[0] <= g) ? 0 : 1;
            op = (win == 0) ? q0.pop_front() : q1.pop_front();
            s = g + 1;
            while (s < len && !w8_s[s]) s++;
            a = s + 1;
            k = -1;
            if (op.pulse) begin
                k = s + 1;
                cntw = 0;
                while (k < len && !(y8_s[k] && cntw >= int'(op.dur))) begin
                    if (w8_s[k]) cntw++;
                    k++;
                end
                a = k + 1;
            end
            if (a >= len) begin
                checks++;
                errors++;
                $error("FAIL model_overrun observed=%0d expected<%0d", a, len);
                break;
            end
            for (int c = r[win]; c <= a; c++) req_s[win][c] = 1'b1;
            addr_s[win][g]  = op.addr;
            pulse_s[win][g] = op.pulse;
            dur_s[win][g]   = op.dur;
            for (int c = g + 1; c <= a; c++) begin
                e_adv[c]  = 1'b1;
                e_addr[c] = op.addr;
            end
            e_set[s] = 1'b1;
            if (k >= 0) e_clr[k] = 1'b1;
            e_ack[win][a] = 1'b1;
            for (int c = g + 1; c < len; c++) e_last[c] = (win == 1);
            last = win;
            idle_from = a + 1;
            ready[win] = a + 2;
        end
    endtask

    task automatic drive(input int c);
        W8 = w8_s[c]; Y8 = y8_s[c];
        REQ0 = req_s[0][c]; ADDR0 = addr_s[0][c]; PULSE0 = pulse_s[0][c]; DUR0 = dur_s[0][c];
        REQ1 = req_s[1][c]; ADDR1 = addr_s[1][c]; PULSE1 = pulse_s[1][c]; DUR1 = dur_s[1][c];
    endtask

    task automatic check_cycle(input int c);
        chk("adv",      c, 8'(ADV),      8'(e_adv[c]));
        chk("busy",     c, 8'(BUSY),     8'(e_adv[c]));
        chk("a_dv",     c, 8'(A_DV),     8'(e_addr[c]));
        chk("set_stb",  c, 8'(SET_STB),  8'(e_set[c]));
        chk("clr_stb",  c, 8'(CLR_STB),  8'(e_clr[c]));
        chk("ack0",     c, 8'(ACK0),     8'(e_ack[0][c]));
        chk("ack1",     c, 8'(ACK1),     8'(e_ack[1][c]));
        chk("last_gnt", c, 8'(LAST_GNT), 8'(e_last[c]));
    endtask

    task automatic run_scenario(input int len, input int abort_at);
        build_model(len);
        SIM_RST = 1'b0;
        W8 = 0; Y8 = 0; REQ0 = 0; REQ1 = 0; PULSE0 = 0; PULSE1 = 0;
        ADDR0 = '0; ADDR1 = '0; DUR0 = '0; DUR1 = '0;
        repeat (2) @(posedge SIM_CLK);
        #1 SIM_RST = 1'b1;
        for (int c = 0; c < len; c++) begin
            if (c > 0) begin
                @(posedge SIM_CLK);
                #1;
            end
            drive(c);
            if (c == abort_at) begin
                #2 SIM_RST = 1'b0;
                W8 = 1'b1; Y8 = 1'b1;
                #1;
                chk("rst_adv",  c, 8'(ADV),     8'h00);
                chk("rst_busy", c, 8'(BUSY),    8'h00);
                chk("rst_a_dv", c, 8'(A_DV),    8'h00);
                chk("rst_set",  c, 8'(SET_STB), 8'h00);
                chk("rst_clr",  c, 8'(CLR_STB), 8'h00);
                chk("rst_last", c, 8'(LAST_GNT), 8'h00);
                for (int i = 1; i <= 3; i++) begin
                    @(negedge SIM_CLK);
                    chk("rst_ack0", c + i, 8'(ACK0), 8'h00);
                    chk("rst_ack1", c + i, 8'(ACK1), 8'h00);
                    chk("rst_advh", c + i, 8'(ADV),  8'h00);
                end
                return;
            end
            @(negedge SIM_CLK);
            check_cycle(c);
        end
    endtask

    initial begin
        // Single set-only request from req0, W8 one cycle after the grant.
        clear_scenario();
        w8_s[3] = 1'b1;
        q0.push_back('{earliest: 2, gap: 0, addr: LATCH_MODA, pulse: 1'b0, dur: 4'd0});
        run_scenario(12, -1);

        // Pulsed EMA from req1, DUR=2, W8 every 8 cycles, Y8 four cycles later.
        clear_scenario();
        for (int c = 3; c < 60; c += 8) begin
            w8_s[c] = 1'b1;
            if (c + 4 < 60) y8_s[c + 4] = 1'b1;
        end
        q1.push_back('{earliest: 2, gap: 0, addr: LATCH_EMA, pulse: 1'b1, dur: 4'd2});
        run_scenario(60, -1);

        // Both requesters at once, two requests each: grant order 0,1,0,1.
        clear_scenario();
        for (int c = 0; c < 80; c++) begin
            w8_s[c] = (c % 3 == 0);
            y8_s[c] = (c % 3 == 1);
        end
        for (int i = 0; i < 2; i++) begin
            q0.push_back('{earliest: 1, gap: 0, addr: LATCH_SSDO, pulse: 1'b1, dur: 4'(i)});
            q1.push_back('{earliest: 1, gap: 0, addr: LATCH_CODE, pulse: 1'(i), dur: 4'd1});
        end
        run_scenario(80, -1);

        // HOLD with cnt==0 and W8/Y8 coincident: clear fires.
        clear_scenario();
        w8_s[2] = 1'b1; w8_s[4] = 1'b1; w8_s[9] = 1'b1;
        y8_s[3] = 1'b1; y8_s[9] = 1'b1;
        q0.push_back('{earliest: 1, gap: 0, addr: LATCH_SSDO, pulse: 1'b1, dur: 4'd1});
        run_scenario(16, -1);

        // DUR=0 pulse: set and Y8 together in ARM (set wins), clear at next Y8.
        clear_scenario();
        w8_s[3] = 1'b1;
        y8_s[3] = 1'b1; y8_s[6] = 1'b1;
        q1.push_back('{earliest: 1, gap: 0, addr: LATCH_CODE, pulse: 1'b1, dur: 4'd0});
        run_scenario(12, -1);

        // Asynchronous reset while in HOLD.
        clear_scenario();
        w8_s[3] = 1'b1; w8_s[8] = 1'b1; w8_s[9] = 1'b1; w8_s[10] = 1'b1;
        y8_s[5] = 1'b1; y8_s[12] = 1'b1;
        q1.push_back('{earliest: 1, gap: 0, addr: LATCH_EMA, pulse: 1'b1, dur: 4'd3});
        run_scenario(20, 6);

        // Randomized traffic after the reset release.
        clear_scenario();
        for (int c = 0; c < 1500; c++) begin
            w8_s[c] = ($urandom_range(0, 3) == 0);
            y8_s[c] = ($urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 20; i++) begin
            q0.push_back('{earliest: 0, gap: int'($urandom_range(0, 6)), addr: 5'($urandom),
                           pulse: 1'($urandom), dur: 4'($urandom_range(0, 5))});
            q1.push_back('{earliest: 0, gap: int'($urandom_range(0, 6)), addr: 5'($urandom),
                           pulse: 1'($urandom), dur: 4'($urandom_range(0, 5))});
        end
        run_scenario(1500, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
